// File: rtl/gps_pkg.sv
// Shared GPS definitions: C/A code length, G2 phase-selector taps per satellite, acquisition states.
package gps_pkg;

    localparam int CA_LEN = 1023;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_SLIP  = 2'd2,
        ST_DONE  = 2'd3
    } acq_state_t;

    // G2 tap pair per n_sat (PRN-1): high nibble / low nibble are 1-based register positions.
    localparam logic [7:0] G2_TAPS [32] = '{
        8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
        8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
        8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
        8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
    };

    function automatic logic [9:0] g2_tap_mask(input logic [4:0] n_sat);
        logic [7:0] t;
        t = G2_TAPS[n_sat];
        return (10'd1 << (t[7:4] - 4'd1)) | (10'd1 << (t[3:0] - 4'd1));
    endfunction

endpackage

// File: rtl/gps_ca_acq_if.sv
// Control, sample and result bundle of the C/A acquisition block.
interface gps_ca_acq_if;
    logic       start_in;
    logic [4:0] n_sat_in;
    logic       sample_in;
    logic       sample_valid_in;
    logic       busy_out;
    logic       done_out;
    logic       lock_out;
    logic [9:0] phase_out;
    logic [10:0] peak_out;

    modport master (
        output start_in, n_sat_in, sample_in, sample_valid_in,
        input  busy_out, done_out, lock_out, phase_out, peak_out
    );

    modport slave (
        input  start_in, n_sat_in, sample_in, sample_valid_in,
        output busy_out, done_out, lock_out, phase_out, peak_out
    );
endinterface

// File: rtl/gc_gen_sync.sv
// Gold-code (C/A) generator with synchronous all-ones reload and chip enable.
module gc_gen_sync
    import gps_pkg::*;
(
    input  logic       clk_in,
    input  logic       load,
    input  logic       en,
    input  logic [4:0] n_sat,
    output logic       chip
);
    // bit i holds shift-register position i+1; new bits enter at position 1
    logic [9:0] g1;
    logic [9:0] g2;

    always_ff @(posedge clk_in) begin
        if (load) begin
            g1 <= '1;
            g2 <= '1;
        end else if (en) begin
            g1 <= {g1[8:0], g1[2] ^ g1[9]};
            g2 <= {g2[8:0], g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9]};
        end
    end

    assign chip = g1[9] ^ (^(g2 & g2_tap_mask(n_sat)));

endmodule

// File: rtl/gps_ca_acq.sv
// Serial C/A code-phase search: one-period correlation per phase, one-chip slip between dwells.
module gps_ca_acq
    import gps_pkg::*;
#(
    parameter int THRESH    = 700,
    parameter int SLIP_LAST = CA_LEN - 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    gps_ca_acq_if.slave acq
);
    acq_state_t  state;
    acq_state_t  state_nx;
    logic [9:0]  cc;
    logic [9:0]  s;
    logic [9:0]  bs;
    logic [9:0]  bs_new;
    logic [10:0] mc;
    logic [10:0] mc_final;
    logic [10:0] bp;
    logic [10:0] bp_new;
    logic [4:0]  n_sat_q;
    logic        local_chip;
    logic        match;
    logic        accept;
    logic        gen_load;
    logic        gen_en;
    logic        dwell_end;
    logic        search_end;
    logic        better;

    assign accept     = acq.start_in && (state == ST_IDLE || state == ST_DONE);
    assign gen_load   = rst_in || accept;
    assign gen_en     = (state == ST_DWELL) && acq.sample_valid_in;
    assign match      = ~(acq.sample_in ^ local_chip);
    assign mc_final   = mc + {10'd0, match};
    assign dwell_end  = gen_en && (cc == 10'(CA_LEN - 1));
    assign search_end = dwell_end && (s == 10'(SLIP_LAST));
    // strict compare keeps the earliest slip on ties
    assign better     = mc_final > bp;
    assign bp_new     = better ? mc_final : bp;
    assign bs_new     = better ? s : bs;

    gc_gen_sync u_gen (
        .clk_in (clk_in),
        .load   (gen_load),
        .en     (gen_en),
        .n_sat  (n_sat_q),
        .chip   (local_chip)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: if (accept) state_nx = ST_DWELL;
            ST_DWELL:         if (dwell_end) state_nx = search_end ? ST_DONE : ST_SLIP;
            ST_SLIP:          if (acq.sample_valid_in) state_nx = ST_DWELL;
            default:          state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            n_sat_q <= '0;
            cc      <= '0;
            mc      <= '0;
            s       <= '0;
            bp      <= '0;
            bs      <= '0;
        end else if (accept) begin
            n_sat_q <= acq.n_sat_in;
            cc      <= '0;
            mc      <= '0;
            s       <= '0;
            bp      <= '0;
            bs      <= '0;
        end else if (acq.sample_valid_in) begin
            if (state == ST_DWELL) begin
                if (dwell_end) begin
                    cc <= '0;
                    mc <= '0;
                    bp <= bp_new;
                    bs <= bs_new;
                end else begin
                    cc <= cc + 10'd1;
                    mc <= mc_final;
                end
            end else if (state == ST_SLIP) begin
                s <= s + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acq.busy_out  <= 1'b0;
            acq.done_out  <= 1'b0;
            acq.lock_out  <= 1'b0;
            acq.phase_out <= '0;
            acq.peak_out  <= '0;
        end else begin
            acq.busy_out <= (state_nx == ST_DWELL) || (state_nx == ST_SLIP);
            acq.done_out <= search_end;
            if (accept) acq.lock_out <= 1'b0;
            if (search_end) begin
                acq.lock_out  <= bp_new >= 11'(THRESH);
                acq.phase_out <= (bs_new == '0) ? '0 : 10'(CA_LEN) - bs_new;
                acq.peak_out  <= bp_new;
            end
        end
    end

endmodule

// File: tb/tb_gps_ca_acq.sv
// Bench for gps_ca_acq with a shortened slip range: table-driven searches, corner sequences, random streams.
`timescale 1ns/1ps
module tb_gps_ca_acq;
    import gps_pkg::*;

    localparam int SL    = 3;
    localparam int TOTAL = (SL + 1) * CA_LEN + SL;
    localparam int SLEN  = TOTAL + 16;
    localparam int TAP_A [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    localparam int TAP_B [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

    typedef struct {
        int tx;
        int rx;
        int k;
        int stride;
        int flips;
        int e_phase;
        int e_peak;
        int e_lock;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gps_ca_acq_if acq ();
    gps_ca_acq #(.THRESH(700), .SLIP_LAST(SL)) dut (.clk_in(clk), .rst_in(rst), .acq(acq));

    int   checks     = 0;
    int   errors     = 0;
    int   prev_phase = 0;
    int   prev_peak  = 0;
    int   res_peak;
    int   res_lock;
    bit   code   [32][CA_LEN];
    bit   stream [SLEN];
    vec_t tv     [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic chk_le(input string name, input int act, input int lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s: got %0d, required <= %0d", name, act, lim);
        end
    endtask

    // C/A codes from the G1/G2 sequence recurrences, chip n = G1[n] ^ G2 delayed by the two taps
    task automatic build_codes();
        bit g1 [CA_LEN + 10];
        bit g2 [CA_LEN + 10];
        for (int i = 0; i < 10; i++) begin
            g1[i] = 1'b1;
            g2[i] = 1'b1;
        end
        for (int n = 0; n < CA_LEN; n++) begin
            g1[n + 10] = g1[n + 7] ^ g1[n];
            g2[n + 10] = g2[n + 8] ^ g2[n + 7] ^ g2[n + 4] ^ g2[n + 2] ^ g2[n + 1] ^ g2[n];
        end
        for (int p = 0; p < 32; p++)
            for (int n = 0; n < CA_LEN; n++)
                code[p][n] = g1[n] ^ g2[n + 10 - TAP_A[p]] ^ g2[n + 10 - TAP_B[p]];
    endtask

    // incoming stream leads the reset-state code by k chips; first `flips` chips inverted, plus random noise
    task automatic fill(input int tx, input int k, input int flips, input int noise_pct);
        for (int n = 0; n < SLEN; n++) begin
            stream[n] = code[tx][(n + k) % CA_LEN] ^ (n < flips);
            if (noise_pct > 0 && int'($urandom_range(99, 0)) < noise_pct) stream[n] = ~stream[n];
        end
    endtask

    // dwell s correlates valid samples s*1024 .. s*1024+1022 against one code period
    function automatic void model(input int rx, output int peak, output int phase);
        int bp = 0;
        int bs = 0;
        int m;
        for (int s = 0; s <= SL; s++) begin
            m = 0;
            for (int j = 0; j < CA_LEN; j++)
                if (stream[s * (CA_LEN + 1) + j] == code[rx][j]) m++;
            if (m > bp) begin
                bp = m;
                bs = s;
            end
        end
        peak  = bp;
        phase = (bs == 0) ? 0 : CA_LEN - bs;
    endfunction

    task automatic run_search(input string tag, input int rx, input int stride, input int rst_at,
                              input int poke_at, input int e_phase, input int e_peak, input int e_lock);
        int n = 0;
        int cyc = 0;
        int guard;
        bit got = 1'b0;
        bit poked = 1'b0;
        bit v;
        guard = TOTAL * 3 + 64;
        acq.start_in        = 1'b1;
        acq.n_sat_in        = 5'(rx);
        acq.sample_valid_in = 1'b1;
        acq.sample_in       = 1'($urandom);
        step();
        acq.start_in = 1'b0;
        acq.n_sat_in = 5'($urandom);
        chk({tag, " busy_after_start"}, int'(acq.busy_out), 1);
        chk({tag, " done_after_start"}, int'(acq.done_out), 0);
        chk({tag, " lock_cleared"}, int'(acq.lock_out), 0);
        chk({tag, " phase_held"}, int'(acq.phase_out), prev_phase);
        chk({tag, " peak_held"}, int'(acq.peak_out), prev_peak);
        while (!got && cyc < guard) begin
            if (stride == 0) v = ($urandom_range(2, 0) != 0);
            else             v = (cyc % stride) == 0;
            if (n >= TOTAL) v = 1'b0;
            if (rst_at >= 0 && n == rst_at) begin
                rst                 = 1'b1;
                acq.sample_valid_in = 1'b1;
                acq.sample_in       = stream[n];
                step();
                rst                 = 1'b0;
                acq.sample_valid_in = 1'b0;
                chk({tag, " rst_busy"}, int'(acq.busy_out), 0);
                chk({tag, " rst_done"}, int'(acq.done_out), 0);
                chk({tag, " rst_lock"}, int'(acq.lock_out), 0);
                chk({tag, " rst_phase"}, int'(acq.phase_out), 0);
                chk({tag, " rst_peak"}, int'(acq.peak_out), 0);
                prev_phase = 0;
                prev_peak  = 0;
                return;
            end
            acq.start_in = (poke_at >= 0 && n == poke_at && !poked);
            if (acq.start_in) poked = 1'b1;
            acq.sample_valid_in = v;
            acq.sample_in       = v ? stream[n] : 1'($urandom);
            step();
            cyc++;
            if (v) n++;
            if (acq.done_out) begin
                got = 1'b1;
                chk({tag, " done_valid_count"}, n, TOTAL);
                chk({tag, " done_after_last_valid"}, int'(v), 1);
                chk({tag, " busy_at_done"}, int'(acq.busy_out), 0);
                chk({tag, " phase"}, int'(acq.phase_out), e_phase);
                chk({tag, " peak"}, int'(acq.peak_out), e_peak);
                chk({tag, " lock"}, int'(acq.lock_out), e_lock);
            end
        end
        acq.start_in        = 1'b0;
        acq.sample_valid_in = 1'b0;
        if (!got) begin
            chk({tag, " done_seen"}, 0, 1);
        end else begin
            step();
            chk({tag, " done_pulse_width"}, int'(acq.done_out), 0);
            chk({tag, " phase_hold"}, int'(acq.phase_out), e_phase);
            prev_phase = e_phase;
            prev_peak  = e_peak;
        end
        res_peak = int'(acq.peak_out);
        res_lock = int'(acq.lock_out);
    endtask

    initial begin
        build_codes();
        rst                 = 1'b1;
        acq.start_in        = 1'b0;
        acq.n_sat_in        = '0;
        acq.sample_in       = 1'b0;
        acq.sample_valid_in = 1'b0;
        repeat (3) step();
        chk("reset busy", int'(acq.busy_out), 0);
        chk("reset done", int'(acq.done_out), 0);
        chk("reset lock", int'(acq.lock_out), 0);
        chk("reset phase", int'(acq.phase_out), 0);
        chk("reset peak", int'(acq.peak_out), 0);
        rst = 1'b0;
        step();
        chk("idle busy", int'(acq.busy_out), 0);

        //        tx rx k     stride flips phase peak lock
        tv[0] = '{0, 0, 0,    1,     0,    0,    1023, 1};
        tv[1] = '{6, 6, 1022, 1,     0,    1022, 1023, 1};
        tv[2] = '{2, 2, 1021, 3,     0,    1021, 1023, 1};
        tv[3] = '{0, 0, 0,    1,     323,  0,    700,  1};
        tv[4] = '{0, 0, 0,    1,     324,  0,    699,  0};
        tv[5] = '{9, 9, 1020, 0,     0,    1020, 1023, 1};
        for (int i = 0; i < 6; i++) begin
            fill(tv[i].tx, tv[i].k, tv[i].flips, 0);
            run_search($sformatf("vec%0d", i), tv[i].rx, tv[i].stride, -1, -1,
                       tv[i].e_phase, tv[i].e_peak, tv[i].e_lock);
        end

        // reset in the middle of dwell 2, then a clean rerun with an ignored start while busy
        fill(3, 1022, 0, 0);
        run_search("rst_mid", 3, 1, 2 * (CA_LEN + 1) + 500, -1, 0, 0, 0);
        run_search("rerun", 3, 1, -1, 1500, 1022, 1023, 1);

        begin
            int mp;
            int mph;
            fill(0, 0, 0, 0);
            model(1, mp, mph);
            run_search("wrong_sat", 1, 1, -1, -1, mph, mp, int'(mp >= 700));
            chk_le("wrong_sat peak_bound", res_peak, 575);
            chk("wrong_sat no_lock", res_lock, 0);
        end

        for (int r = 0; r < 3; r++) begin
            int sat;
            int k;
            int mp;
            int mph;
            sat = int'($urandom_range(31, 0));
            k   = (r == 1) ? int'($urandom_range(1022, 0))
                           : (CA_LEN - int'($urandom_range(SL, 0))) % CA_LEN;
            fill(sat, k, 0, int'($urandom_range(15, 0)));
            model(sat, mp, mph);
            run_search($sformatf("rand%0d", r), sat, (r == 2) ? 0 : int'($urandom_range(2, 1)),
                       -1, -1, mph, mp, int'(mp >= 700));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
